// File: rtl/robertson_mult_seq_pkg.sv
// Shared constants for the Robertson sequential multiplier: FSM state encoding
// and the add/subtract select polarity of the extended adder.
package robertson_mult_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ADD   = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic ADDSUB_ADD = 1'b1;
    localparam logic ADDSUB_SUB = 1'b0;

endpackage

// File: rtl/robertson_mult_seq_ext_addsub.sv
// Combinational W-bit adder/subtractor; carry-out is discarded.
module ext_addsub
    import robertson_mult_seq_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] dataa,
    input  logic [W-1:0] datab,
    input  logic         add_sub,
    output logic [W-1:0] result
);

    always_comb begin
        result = dataa - datab;
        if (add_sub == ADDSUB_ADD) begin
            result = dataa + datab;
        end
    end

endmodule

// File: rtl/robertson_mult_seq.sv
// Sequential signed multiplier (Robertson's algorithm): one add/subtract and one
// arithmetic right shift of {F,A,Q} per multiplier bit, start/done handshake.
module robertson_mult_seq
    import robertson_mult_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

    state_t         state_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   q_q;
    logic [N-1:0]   m_q;
    logic           f_q;
    logic [CW-1:0]  cnt_q;
    logic [2*N-1:0] product_q;
    logic           busy_q;
    logic           done_q;

    logic           add_sel_d;
    logic [N:0]     fa_d;

    // The last step weights the multiplier's sign bit negatively, so it subtracts.
    always_comb begin
        add_sel_d = ADDSUB_SUB;
        if (cnt_q != '0) begin
            add_sel_d = ADDSUB_ADD;
        end
    end

    ext_addsub #(
        .W(N + 1)
    ) u_addsub (
        .dataa  ({f_q, a_q}),
        .datab  ({m_q[N-1], m_q}),
        .add_sub(add_sel_d),
        .result (fa_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            f_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        m_q     <= multiplicand;
                        q_q     <= multiplier;
                        a_q     <= '0;
                        f_q     <= 1'b0;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    if (q_q[0]) begin
                        {f_q, a_q} <= fa_d;
                    end
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    {f_q, a_q, q_q} <= {f_q, f_q, a_q, q_q[N-1:1]};
                    if (cnt_q != '0) begin
                        cnt_q   <= cnt_q - 1'b1;
                        state_q <= ST_ADD;
                    end else begin
                        // Post-shift {A,Q} is the full product.
                        product_q <= {f_q, a_q, q_q[N-1:1]};
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
